// File: rtl/int_closest_hit.sv
// Closest-hit merge stage: folds per-triangle results into one entry per ray
// and queues finished rays in a registered FIFO toward the shader/miss router.
module int_closest_hit #(
  parameter int RAYID_W   = 8,
  parameter int TRIID_W   = 16,
  parameter int SLOT_W    = 4,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  input  logic               res_hit,
  input  logic               res_last,
  input  logic [RAYID_W-1:0] res_rayID,
  input  logic [31:0]        res_t,
  input  logic [31:0]        res_u,
  input  logic [31:0]        res_v,
  input  logic [TRIID_W-1:0] res_triID,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RAYID_W-1:0] out_rayID,
  output logic               out_hit,
  output logic [31:0]        out_t,
  output logic [31:0]        out_u,
  output logic [31:0]        out_v,
  output logic [TRIID_W-1:0] out_triID,
  output logic               almost_full,
  output logic               overflow,
  output logic               collision
);

  localparam int NSLOT = 1 << SLOT_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL_C = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [31:0]      T_INF    = 32'h7F80_0000;

  typedef struct packed {
    logic [RAYID_W-1:0] ray;
    logic               hit;
    logic [31:0]        t;
    logic [31:0]        u;
    logic [31:0]        v;
    logic [TRIID_W-1:0] tri_id;
  } entry_t;

  logic               occ_r  [NSLOT];
  entry_t             slot_r [NSLOT];
  entry_t             mem_r  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               out_valid_r;
  logic               almost_full_r;
  logic               overflow_r;
  logic               collision_r;

  logic [SLOT_W-1:0]  slot_idx_s;
  entry_t             cur_s;
  entry_t             inc_s;
  entry_t             merged_s;
  logic               tag_match_s;
  logic               collide_s;
  logic               push_s;
  logic               pop_s;
  logic               accept_s;
  logic               drop_s;
  logic [CNT_W-1:0]   count_next_s;

  // Merge the incoming result with its slot; t compares as unsigned since t >= +0.0.
  always_comb begin
    slot_idx_s    = res_rayID[SLOT_W-1:0];
    cur_s         = slot_r[slot_idx_s];
    inc_s.ray     = res_rayID;
    inc_s.hit     = res_hit;
    inc_s.t       = res_hit ? res_t     : T_INF;
    inc_s.u       = res_hit ? res_u     : 32'h0000_0000;
    inc_s.v       = res_hit ? res_v     : 32'h0000_0000;
    inc_s.tri_id  = res_hit ? res_triID : {TRIID_W{1'b0}};
    tag_match_s   = occ_r[slot_idx_s] && (cur_s.ray == res_rayID);
    collide_s     = res_valid && occ_r[slot_idx_s] && (cur_s.ray != res_rayID);
    if (!tag_match_s) begin
      merged_s = inc_s;
    end else if (res_hit && (!cur_s.hit || (res_t < cur_s.t))) begin
      merged_s = inc_s;
    end else begin
      merged_s = cur_s;
    end
  end

  // FIFO push/pop arbitration; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    push_s   = res_valid && res_last;
    pop_s    = out_valid_r && out_ready;
    accept_s = push_s && ((count_r < DEPTH_C) || pop_s);
    drop_s   = push_s && !accept_s;
    case ({accept_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Merge table: last result frees the slot at the same edge it is pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        occ_r[i]  <= 1'b0;
        slot_r[i] <= '0;
      end
    end else if (res_valid) begin
      occ_r[slot_idx_s]  <= !res_last;
      slot_r[slot_idx_s] <= merged_s;
    end
  end

  // Output FIFO storage, pointers, count and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      collision_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= merged_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r       <= count_next_s;
      out_valid_r   <= (count_next_s != {CNT_W{1'b0}});
      almost_full_r <= (count_next_s >= AF_LVL_C);
      overflow_r    <= overflow_r | drop_s;
      collision_r   <= collision_r | collide_s;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_rayID   = mem_r[rd_ptr_r].ray;
  assign out_hit     = mem_r[rd_ptr_r].hit;
  assign out_t       = mem_r[rd_ptr_r].t;
  assign out_u       = mem_r[rd_ptr_r].u;
  assign out_v       = mem_r[rd_ptr_r].v;
  assign out_triID   = mem_r[rd_ptr_r].tri_id;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;
  assign collision   = collision_r;

endmodule

// File: tb/tb_int_closest_hit.sv
// Directed bench for int_closest_hit: hand-computed expectations checked with
// immediate assertions at each step.
module tb_int_closest_hit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_hit = 1'b0;
  logic        res_last = 1'b0;
  logic [7:0]  res_rayID = 8'h00;
  logic [31:0] res_t = 32'h0;
  logic [31:0] res_u = 32'h0;
  logic [31:0] res_v = 32'h0;
  logic [15:0] res_triID = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_rayID;
  logic        out_hit;
  logic [31:0] out_t;
  logic [31:0] out_u;
  logic [31:0] out_v;
  logic [15:0] out_triID;
  logic        almost_full;
  logic        overflow;
  logic        collision;

  int vecs = 0;
  int errs = 0;

  int_closest_hit dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_hit(res_hit), .res_last(res_last),
    .res_rayID(res_rayID), .res_t(res_t), .res_u(res_u), .res_v(res_v),
    .res_triID(res_triID),
    .out_valid(out_valid), .out_ready(out_ready), .out_rayID(out_rayID),
    .out_hit(out_hit), .out_t(out_t), .out_u(out_u), .out_v(out_v),
    .out_triID(out_triID),
    .almost_full(almost_full), .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] ray, input logic hit, input logic last,
                      input logic [31:0] t, input logic [15:0] tri_id,
                      input logic [31:0] u, input logic [31:0] v);
    res_valid = 1'b1; res_rayID = ray; res_hit = hit; res_last = last;
    res_t = t; res_triID = tri_id; res_u = u; res_v = v;
    @(posedge clk); #1;
    res_valid = 1'b0; res_last = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_af",    64'(almost_full), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_col",   64'(collision), 64'd0);
    chk("rst_t",     64'(out_t), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // single ray, one result, visible the cycle after
    send(8'd3, 1'b1, 1'b1, 32'h40A0_0000, 16'h0033, 32'h3F80_0000, 32'h4000_0000);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_ray",   64'(out_rayID), 64'd3);
    chk("single_hit",   64'(out_hit), 64'd1);
    chk("single_t",     64'(out_t), 64'h40A0_0000);
    chk("single_tri",   64'(out_triID), 64'h0033);
    chk("single_u",     64'(out_u), 64'h3F80_0000);
    chk("single_v",     64'(out_v), 64'h4000_0000);
    pop();
    chk("single_popped", 64'(out_valid), 64'd0);

    // three results for ray 7, min t wins
    send(8'd7, 1'b1, 1'b0, 32'h4100_0000, 16'h0701, 32'h1, 32'h2);
    send(8'd7, 1'b0, 1'b0, 32'h3F00_0000, 16'h0702, 32'h3, 32'h4);
    chk("r7_not_yet", 64'(out_valid), 64'd0);
    send(8'd7, 1'b1, 1'b1, 32'h40A0_0000, 16'h0703, 32'h5, 32'h6);
    chk("r7_t",   64'(out_t), 64'h40A0_0000);
    chk("r7_tri", 64'(out_triID), 64'h0703);
    pop();

    // tie keeps the earlier triangle
    send(8'd7, 1'b1, 1'b0, 32'h40A0_0000, 16'h0711, 32'h7, 32'h8);
    send(8'd7, 1'b1, 1'b1, 32'h40A0_0000, 16'h0712, 32'h9, 32'hA);
    chk("tie_tri", 64'(out_triID), 64'h0711);
    chk("tie_u",   64'(out_u), 64'h7);
    pop();

    // all-miss ray, garbage on t/u/v/tri must not leak
    send(8'd2, 1'b0, 1'b0, 32'h1234_5678, 16'hBEEF, 32'h1111, 32'h2222);
    send(8'd2, 1'b0, 1'b1, 32'h0000_0001, 16'hCAFE, 32'h3333, 32'h4444);
    chk("miss_ray", 64'(out_rayID), 64'd2);
    chk("miss_hit", 64'(out_hit), 64'd0);
    chk("miss_t",   64'(out_t), 64'h7F80_0000);
    chk("miss_u",   64'(out_u), 64'd0);
    chk("miss_v",   64'(out_v), 64'd0);
    chk("miss_tri", 64'(out_triID), 64'd0);
    pop();

    // interleaved rays 1 and 2
    send(8'd1, 1'b1, 1'b0, 32'h4080_0000, 16'h0101, 32'h0, 32'h0);
    send(8'd2, 1'b1, 1'b0, 32'h4000_0000, 16'h0201, 32'h0, 32'h0);
    send(8'd1, 1'b1, 1'b1, 32'h4040_0000, 16'h0102, 32'h0, 32'h0);
    send(8'd2, 1'b1, 1'b1, 32'h3F80_0000, 16'h0202, 32'h0, 32'h0);
    chk("il_ray1", 64'(out_rayID), 64'd1);
    chk("il_t1",   64'(out_t), 64'h4040_0000);
    chk("il_tri1", 64'(out_triID), 64'h0102);
    pop();
    chk("il_ray2", 64'(out_rayID), 64'd2);
    chk("il_t2",   64'(out_t), 64'h3F80_0000);
    chk("il_tri2", 64'(out_triID), 64'h0202);
    pop();
    chk("il_empty", 64'(out_valid), 64'd0);
    chk("il_nocol", 64'(collision), 64'd0);

    // slot collision: ray 17 lands on ray 1's slot, old contents lost
    send(8'd1, 1'b1, 1'b0, 32'h3F80_0000, 16'h0111, 32'h0, 32'h0);
    send(8'd17, 1'b1, 1'b1, 32'h4100_0000, 16'h1711, 32'h0, 32'h0);
    chk("col_flag", 64'(collision), 64'd1);
    chk("col_ray",  64'(out_rayID), 64'd17);
    chk("col_t",    64'(out_t), 64'h4100_0000);
    pop();

    // fill FIFO with no consumer
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h20 + i), 1'b1, 1'b1, 32'h3F80_0000, 16'(i), 32'h0, 32'h0);
      if (i == 8) chk("af_at9",  64'(almost_full), 64'd0);
      if (i == 9) chk("af_at10", 64'(almost_full), 64'd1);
    end
    chk("full_ovf",  64'(overflow), 64'd0);
    chk("full_head", 64'(out_rayID), 64'h20);
    out_ready = 1'b1;
    send(8'h30, 1'b1, 1'b1, 32'h3F80_0000, 16'h0030, 32'h0, 32'h0);
    out_ready = 1'b0;
    chk("pushpop_ovf",  64'(overflow), 64'd0);
    chk("pushpop_head", 64'(out_rayID), 64'h21);
    send(8'h31, 1'b1, 1'b1, 32'h3F80_0000, 16'h0031, 32'h0, 32'h0);
    chk("drop_ovf",  64'(overflow), 64'd1);
    chk("drop_head", 64'(out_rayID), 64'h21);
    for (int i = 0; i < 16; i++) begin
      chk("drain_ray", 64'(out_rayID), (i < 15) ? 64'(8'h21 + i) : 64'h30);
      pop();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_af",    64'(almost_full), 64'd0);

    // mid-stream reset with occupied slots and queued results
    send(8'd4, 1'b1, 1'b0, 32'h3F80_0000, 16'h0401, 32'h0, 32'h0);
    send(8'd5, 1'b1, 1'b0, 32'h3F80_0000, 16'h0501, 32'h0, 32'h0);
    send(8'd6, 1'b1, 1'b0, 32'h3F80_0000, 16'h0601, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h48 + i), 1'b1, 1'b1, 32'h3F80_0000, 16'h0, 32'h0, 32'h0);
    end
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ovf",   64'(overflow), 64'd0);
    chk("mrst_col",   64'(collision), 64'd0);
    chk("mrst_af",    64'(almost_full), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    send(8'd4, 1'b1, 1'b1, 32'h4000_0000, 16'h0444, 32'h0, 32'h0);
    chk("post_rst_t",   64'(out_t), 64'h4000_0000);
    chk("post_rst_tri", 64'(out_triID), 64'h0444);
    chk("post_rst_col", 64'(collision), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
